adsr_step_counter: RTL
======================

ADSR_STEP_COUNTER -- requirements
Module: adsr_step_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter/step/limit width in bits (legal 2..32).
REQ-002 Parameter RESET_VALUE, default 0, count value forced by reset.
REQ-003 clk  input  1  rising-edge clock; one clock; all state on this clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  advance count by step this cycle.
REQ-006 load  input  1  synchronous load of load_value.
REQ-007 load_value  input  WIDTH  value taken on load.
REQ-008 up  input  1  direction: 1 = count up, 0 = count down.
REQ-009 step  input  WIDTH  unsigned increment magnitude.
REQ-010 sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo 2^WIDTH.
REQ-011 limit  input  WIDTH  compare value for hit_limit.
REQ-012 count  output  WIDTH  registered count.
REQ-013 at_max / at_min  output  1 each  combinational: count == all-ones / count == 0.
REQ-014 wrapped  output  1  registered one-cycle pulse: last step crossed a bound in wrap mode.
REQ-015 saturated  output  1  registered one-cycle pulse: last step was clamped.
REQ-016 hit_limit  output  1  registered one-cycle pulse: last step landed count exactly on limit.

Function
REQ-017 Priority each rising edge: load > en > hold.
REQ-018 load: count <= load_value next edge; wrapped, saturated, hit_limit <= 0 that edge.
REQ-019 en without load: sum = count +/- step computed WIDTH+1 bits wide; carry (up) or borrow (down) = overflow.
REQ-020 No overflow: count <= sum[WIDTH-1:0]; wrapped, saturated <= 0.
REQ-021 Overflow, sat_mode=0: count <= sum[WIDTH-1:0] (modulo); wrapped <= 1 for one cycle.
REQ-022 Overflow, sat_mode=1: count <= all-ones (up) or 0 (down); saturated <= 1 for one cycle.
REQ-023 Step landing exactly on all-ones (up) or 0 (down) is not overflow; no pulse.
REQ-024 hit_limit <= 1 iff en step taken (not load) and new count == limit, including clamped/wrapped results.
REQ-025 en with step=0: count unchanged; hit_limit follows REQ-024 (pulses if count == limit); other pulses 0.
REQ-026 Neither load nor en: count holds; all pulse outputs <= 0.
REQ-027 Latency: one clock from control sample to count and pulse outputs; pulses never exceed one cycle unless the condition recurs next step.
REQ-028 direction, sat_mode, step, limit sampled only in cycles where en is acted on; may change every cycle.

Reset
REQ-029 reset high: count = RESET_VALUE, wrapped = saturated = hit_limit = 0, immediately, independent of clk.
REQ-030 reset overrides load and en; first edge after deassertion applies normal priority.
REQ-031 reset mid-pulse clears pulse at once; no pulse generated by reset itself.

Configuration
REQ-032 Macro ADSR_STEP_COUNTER_SAT_EN defined: saturation logic and saturated output behave per REQ-022.
REQ-033 Macro undefined: sat_mode ignored, all overflow wraps per REQ-021, saturated tied 0; port list unchanged.

Structure
REQ-034 Shared package adsr_counter_pkg: DIR_UP/DIR_DOWN constants, MODE_WRAP/MODE_SAT constants, default WIDTH constant.
REQ-035 One sub-module adsr_addsub: WIDTH-parametrised combinational add/subtract with carry/borrow out; instantiated once.
REQ-036 All registers in top module; no other hierarchy.

Verification (WIDTH=4, RESET_VALUE=0)
REQ-037 Assert reset between edges -> count=0, pulses 0 before next edge; load=1,en=1 held during reset -> no effect.
REQ-038 load_value=13, load=1 -> count=13; then en, up=1, step=2, sat_mode=0 -> count=15; next step -> count=1, wrapped=1 one cycle.
REQ-039 count=14, en, up=1, step=3, sat_mode=1 -> count=15, saturated=1; down, count=2, step=5 -> count=0, saturated=1, at_min=1.
REQ-040 count=5, limit=9, up, step=2, en two cycles -> 7 then 9, hit_limit=1 only on 9; load 9 -> hit_limit=0.
REQ-041 load=1 and en=1 same cycle, load_value=4, count=10 -> count=4, no pulses; en, step=0, limit=4 -> count=4, hit_limit=1.
REQ-042 Build without ADSR_STEP_COUNTER_SAT_EN: count=14, up, step=3, sat_mode=1 -> count=1, wrapped=1, saturated=0.

Source files
------------

// File: rtl/adsr_counter_pkg.sv
// Shared constants for the ADSR step counter: direction and overflow-mode
// encodings plus the default counter width.
package adsr_counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dirE;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } modeE;

endpackage

// File: rtl/adsr_addsub.sv
// Combinational WIDTH-bit add/subtract; o_carry is the carry out on add and
// the borrow out on subtract.
module adsr_addsub
  import adsr_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_full;

  // One extra bit so the top bit reads directly as carry or borrow.
  always_comb begin
    w_full = '0;
    if (i_sub) begin
      w_full = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      w_full = {1'b0, i_a} + {1'b0, i_b};
    end
  end

  assign o_result = w_full[WIDTH-1:0];
  assign o_carry  = w_full[WIDTH];

endmodule

// File: rtl/adsr_step_counter.sv
// Up/down step counter with wrap or saturate on overflow and one-cycle status
// pulses. Saturation is only built in when ADSR_STEP_COUNTER_SAT_EN is defined.
module adsr_step_counter
  import adsr_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped,
  output logic             saturated,
  output logic             hit_limit
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;
  logic             r_saturated;
  logic             r_hitLimit;

  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;
  logic             w_subtract;
  logic             w_satReq;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextWrapped;
  logic             w_nextSaturated;
  logic             w_nextHit;

  assign w_subtract = (up == DIR_DOWN);

  adsr_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a     (r_count),
    .i_b     (step),
    .i_sub   (w_subtract),
    .o_result(w_sum),
    .o_carry (w_overflow)
  );

`ifdef ADSR_STEP_COUNTER_SAT_EN
  assign w_satReq = (sat_mode == MODE_SAT);
`else
  // Without saturation support every overflow wraps; sat_mode has no effect.
  assign w_satReq = sat_mode & 1'b0;
`endif

  always_comb begin
    w_nextCount     = r_count;
    w_nextWrapped   = 1'b0;
    w_nextSaturated = 1'b0;
    w_nextHit       = 1'b0;
    if (load) begin
      w_nextCount = load_value;
    end else if (en) begin
      if (w_overflow && w_satReq) begin
        w_nextCount     = (up == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        w_nextSaturated = 1'b1;
      end else begin
        w_nextCount   = w_sum;
        w_nextWrapped = w_overflow;
      end
      // Limit match is judged on the final (clamped or wrapped) value.
      w_nextHit = (w_nextCount == limit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= RESET_VALUE;
      r_wrapped   <= 1'b0;
      r_saturated <= 1'b0;
      r_hitLimit  <= 1'b0;
    end else begin
      r_count     <= w_nextCount;
      r_wrapped   <= w_nextWrapped;
      r_saturated <= w_nextSaturated;
      r_hitLimit  <= w_nextHit;
    end
  end

  assign count     = r_count;
  assign at_max    = &r_count;
  assign at_min    = ~|r_count;
  assign wrapped   = r_wrapped;
  assign saturated = r_saturated;
  assign hit_limit = r_hitLimit;

endmodule
